mxint_linear_ctrl: RTL and testbench
====================================

MXINT_LINEAR_CTRL -- requirements
Module: mxint_linear_ctrl

Interface
REQ-001 SHALL have parameter HAS_BIAS, default 1: bias stream enabled.
REQ-002 SHALL have parameters WEIGHT_PRECISION_0/1, default 16/3: weight mantissa and exponent widths.
REQ-003 SHALL have parameters WEIGHT_TENSOR_SIZE_DIM_0/1, default 20/20; WEIGHT_PARALLELISM_DIM_0/1, default 4/4.
REQ-004 SHALL have parameters BIAS_PRECISION_0/1, default 16/3; BIAS_TENSOR_SIZE_DIM_0, default 20; BIAS_PARALLELISM_DIM_0, default 4.
REQ-005 SHALL have parameter OUT_BEATS, default 25: number of output-block handshakes per layer run.
REQ-006 SHALL derive W_BLOCKS = (WEIGHT_TENSOR_SIZE_DIM_0*WEIGHT_TENSOR_SIZE_DIM_1)/(WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1) and B_BLOCKS = BIAS_TENSOR_SIZE_DIM_0/BIAS_PARALLELISM_DIM_0 (defaults 25, 5).
REQ-007 SHALL have ports: clk in 1, clock; rst in 1, synchronous active-high reset.
REQ-008 SHALL have ports: start in 1, begin run; busy out 1, run active; done out 1, one-cycle run-complete pulse.
REQ-009 SHALL have ports: wmem_en out 1; wmem_addr out clog2(W_BLOCKS); wmem_rdata in WEIGHT_PRECISION_0*P + WEIGHT_PRECISION_1, where P = WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1 (element 0 at LSBs, exponent in top bits).
REQ-010 SHALL have ports: bmem_en out 1; bmem_addr out clog2(B_BLOCKS); bmem_rdata in BIAS_PRECISION_0*BIAS_PARALLELISM_DIM_0 + BIAS_PRECISION_1, packed the same way.
REQ-011 SHALL have ports: mweight out WEIGHT_PRECISION_0 x P array; eweight out WEIGHT_PRECISION_1; weight_valid out 1; weight_ready in 1.
REQ-012 SHALL have ports: mbias out BIAS_PRECISION_0 x BIAS_PARALLELISM_DIM_0 array; ebias out BIAS_PRECISION_1; bias_valid out 1; bias_ready in 1.
REQ-013 SHALL have ports: out_valid in 1, out_ready in 1 — monitor taps on the linear output handshake.

Function
REQ-014 SHALL implement states IDLE, LOAD, DRAIN, DONE; busy = 1 in LOAD and DRAIN.
REQ-015 IDLE -> LOAD when start = 1; start in any other state SHALL be ignored.
REQ-016 LOAD -> DRAIN when all W_BLOCKS (and B_BLOCKS if HAS_BIAS) stream handshakes are complete; DRAIN -> DONE when the output count reaches OUT_BEATS; DONE -> IDLE after one cycle, with done = 1 only in DONE.
REQ-017 Memory reads SHALL have 1-cycle latency: data on *_rdata is valid in the cycle after *_en = 1.
REQ-018 Each stream SHALL own a 2-entry prefetch FIFO; a read SHALL issue only when occupancy + in-flight reads < 2 and the address is below the stream's block count.
REQ-019 Addresses SHALL issue in increasing order from 0; each address SHALL be read exactly once per run.
REQ-020 *_valid SHALL be driven by FIFO non-empty; data SHALL hold stable while valid = 1 and ready = 0.
REQ-021 With ready held at 1, each stream SHALL sustain 1 block per cycle; first weight_valid SHALL appear 2 cycles after the first wmem_en.
REQ-022 When HAS_BIAS = 0, bmem_en and bias_valid SHALL stay 0, and bias completion SHALL be treated as satisfied.
REQ-023 Output beats (out_valid && out_ready) SHALL be counted only in LOAD/DRAIN, including beats during LOAD; beats in IDLE/DONE SHALL be ignored.
REQ-024 The output counter SHALL saturate at OUT_BEATS.
REQ-025 The weight and bias streams SHALL progress independently; neither SHALL stall the other.

Reset
REQ-026 rst SHALL force state IDLE; zero all counters, addresses and FIFO pointers; drive busy, done, wmem_en, bmem_en, weight_valid and bias_valid to 0.
REQ-027 Reset mid-run SHALL discard in-flight reads; the next start SHALL restart from address 0.

Structure
REQ-028 Package mxint_linear_ctrl_pkg SHALL hold the state enum typedef.
REQ-029 A sub-module mxint_ctrl_prefetch_fifo (2-entry, parameterised width, valid/ready) SHALL be instantiated once per stream.

Verification
REQ-030 Defaults, ready = 1, start pulsed in cycle 0 -> wmem_en = 1 with addr 0 in cycle 1; weight_valid in cycle 3; addresses 0..24 issued contiguously, with no bubbles.
REQ-031 Random weight_ready (50%) -> 25 weight handshakes exactly, in address order, with payload equal to memory contents and held stable while stalled.
REQ-032 HAS_BIAS = 1 -> 5 bias handshakes at addresses 0..4; with HAS_BIAS = 0 -> bias_valid never asserted and done still reached.
REQ-033 25 output beats injected after streams complete -> done is a single-cycle pulse one cycle after the 25th beat, then busy = 0; a 26th beat is ignored.
REQ-034 start re-pulsed during LOAD -> no effect; rst asserted mid-LOAD, then start -> fresh run from addr 0 with full counts.

Source files
------------

// File: rtl/mxint_linear_ctrl_pkg.sv
// Shared types and helpers for the MXINT linear-layer controller.
package mxint_linear_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    // Address width for n blocks, never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/mxint_ctrl_prefetch_fifo.sv
// Two-entry valid/ready prefetch FIFO; head data is held until it is popped.
module mxint_ctrl_prefetch_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push_s, pop_s;

    // Pointer, occupancy and storage updates.
    always_comb begin
        pop_s    = (cnt_q != 2'd0) && out_ready;
        push_s   = in_valid && ((cnt_q != 2'd2) || pop_s);
        wr_ptr_d = wr_ptr_q ^ push_s;
        rd_ptr_d = rd_ptr_q ^ pop_s;
        cnt_d    = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
        for (int i = 0; i < 2; i++) begin
            mem_d[i] = (push_s && (wr_ptr_q == 1'(i))) ? in_data : mem_q[i];
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = cnt_q;

endmodule

// File: rtl/mxint_linear_ctrl.sv
// Run controller for an MXINT linear layer: streams weight/bias blocks out of
// 1-cycle-latency memories and counts output beats until the layer completes.
module mxint_linear_ctrl
    import mxint_linear_ctrl_pkg::*;
#(
    parameter int HAS_BIAS                 = 1,
    parameter int WEIGHT_PRECISION_0       = 16,
    parameter int WEIGHT_PRECISION_1       = 3,
    parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 20,
    parameter int WEIGHT_TENSOR_SIZE_DIM_1 = 20,
    parameter int WEIGHT_PARALLELISM_DIM_0 = 4,
    parameter int WEIGHT_PARALLELISM_DIM_1 = 4,
    parameter int BIAS_PRECISION_0         = 16,
    parameter int BIAS_PRECISION_1         = 3,
    parameter int BIAS_TENSOR_SIZE_DIM_0   = 20,
    parameter int BIAS_PARALLELISM_DIM_0   = 4,
    parameter int OUT_BEATS                = 25,
    localparam int P        = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1,
    localparam int W_BLOCKS = (WEIGHT_TENSOR_SIZE_DIM_0 * WEIGHT_TENSOR_SIZE_DIM_1) / P,
    localparam int B_BLOCKS = BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0,
    localparam int W_AW     = addr_width(W_BLOCKS),
    localparam int B_AW     = addr_width(B_BLOCKS),
    localparam int W_DW     = WEIGHT_PRECISION_0 * P + WEIGHT_PRECISION_1,
    localparam int B_DW     = BIAS_PRECISION_0 * BIAS_PARALLELISM_DIM_0 + BIAS_PRECISION_1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          wmem_en,
    output logic [W_AW-1:0]               wmem_addr,
    input  logic [W_DW-1:0]               wmem_rdata,
    output logic                          bmem_en,
    output logic [B_AW-1:0]               bmem_addr,
    input  logic [B_DW-1:0]               bmem_rdata,
    output logic [WEIGHT_PRECISION_0-1:0] mweight [P],
    output logic [WEIGHT_PRECISION_1-1:0] eweight,
    output logic                          weight_valid,
    input  logic                          weight_ready,
    output logic [BIAS_PRECISION_0-1:0]   mbias [BIAS_PARALLELISM_DIM_0],
    output logic [BIAS_PRECISION_1-1:0]   ebias,
    output logic                          bias_valid,
    input  logic                          bias_ready,
    input  logic                          out_valid,
    input  logic                          out_ready
);

    localparam int WCW = $clog2(W_BLOCKS + 1);
    localparam int BCW = $clog2(B_BLOCKS + 1);
    localparam int OCW = $clog2(OUT_BEATS + 1);
    localparam logic [WCW-1:0] W_LAST  = WCW'(W_BLOCKS);
    localparam logic [BCW-1:0] B_LAST  = BCW'(B_BLOCKS);
    localparam logic [OCW-1:0] O_LAST  = OCW'(OUT_BEATS);
    localparam logic           BIAS_EN = (HAS_BIAS != 32'sd0);

    ctrl_state_e      state_q, state_d;
    logic [WCW-1:0]   w_addr_q, w_addr_d, w_hs_q, w_hs_d;
    logic [BCW-1:0]   b_addr_q, b_addr_d, b_hs_q, b_hs_d;
    logic             w_infl_q, w_infl_d, b_infl_q, b_infl_d;
    logic [OCW-1:0]   out_cnt_q, out_cnt_d;
    logic [1:0]       w_occ_s, b_occ_s, w_level_s, b_level_s;
    logic             w_pop_s, b_pop_s, w_issue_s, b_issue_s;
    logic             run_s, beat_s, w_fin_s, b_fin_s;
    logic [W_DW-1:0]  w_head_s;
    logic [B_DW-1:0]  b_head_s;

    // A read in flight lands in the FIFO on the following cycle.
    mxint_ctrl_prefetch_fifo #(.WIDTH(W_DW)) u_wfifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_infl_q),
        .in_data   (wmem_rdata),
        .out_valid (weight_valid),
        .out_ready (weight_ready),
        .out_data  (w_head_s),
        .count     (w_occ_s)
    );

    mxint_ctrl_prefetch_fifo #(.WIDTH(B_DW)) u_bfifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_infl_q),
        .in_data   (bmem_rdata),
        .out_valid (bias_valid),
        .out_ready (bias_ready),
        .out_data  (b_head_s),
        .count     (b_occ_s)
    );

    // Read issue: the slot freed by a same-cycle pop is reusable, giving 1 block/cycle.
    always_comb begin
        run_s     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
        w_pop_s   = weight_valid && weight_ready;
        b_pop_s   = bias_valid && bias_ready;
        w_level_s = w_occ_s - {1'b0, w_pop_s} + {1'b0, w_infl_q};
        b_level_s = b_occ_s - {1'b0, b_pop_s} + {1'b0, b_infl_q};
        w_issue_s = (state_q == ST_LOAD) && (w_addr_q < W_LAST) && (w_level_s < 2'd2);
        b_issue_s = BIAS_EN && (state_q == ST_LOAD) && (b_addr_q < B_LAST) && (b_level_s < 2'd2);
        w_fin_s   = (w_hs_q == W_LAST);
        b_fin_s   = !BIAS_EN || (b_hs_q == B_LAST);
        beat_s    = run_s && out_valid && out_ready && (out_cnt_q != O_LAST);
    end

    // Next-state and counter updates.
    always_comb begin
        state_d   = state_q;
        w_addr_d  = w_issue_s ? (w_addr_q + WCW'(1)) : w_addr_q;
        b_addr_d  = b_issue_s ? (b_addr_q + BCW'(1)) : b_addr_q;
        w_infl_d  = w_issue_s;
        b_infl_d  = b_issue_s;
        w_hs_d    = (run_s && w_pop_s) ? (w_hs_q + WCW'(1)) : w_hs_q;
        b_hs_d    = (run_s && b_pop_s) ? (b_hs_q + BCW'(1)) : b_hs_q;
        out_cnt_d = beat_s ? (out_cnt_q + OCW'(1)) : out_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    w_addr_d  = '0;
                    b_addr_d  = '0;
                    w_hs_d    = '0;
                    b_hs_d    = '0;
                    out_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_fin_s && b_fin_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (out_cnt_d == O_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            w_addr_q  <= '0;
            b_addr_q  <= '0;
            w_hs_q    <= '0;
            b_hs_q    <= '0;
            w_infl_q  <= 1'b0;
            b_infl_q  <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            w_addr_q  <= w_addr_d;
            b_addr_q  <= b_addr_d;
            w_hs_q    <= w_hs_d;
            b_hs_q    <= b_hs_d;
            w_infl_q  <= w_infl_d;
            b_infl_q  <= b_infl_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Unpack FIFO heads: element 0 at the LSBs, exponent in the top bits.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            mweight[i] = w_head_s[i*WEIGHT_PRECISION_0 +: WEIGHT_PRECISION_0];
        end
        eweight = w_head_s[W_DW-1 -: WEIGHT_PRECISION_1];
        for (int i = 0; i < BIAS_PARALLELISM_DIM_0; i++) begin
            mbias[i] = b_head_s[i*BIAS_PRECISION_0 +: BIAS_PRECISION_0];
        end
        ebias = b_head_s[B_DW-1 -: BIAS_PRECISION_1];
    end

    assign busy      = run_s;
    assign done      = (state_q == ST_DONE);
    assign wmem_en   = w_issue_s;
    assign bmem_en   = b_issue_s;
    assign wmem_addr = w_addr_q[W_AW-1:0];
    assign bmem_addr = b_addr_q[B_AW-1:0];

endmodule

// File: tb/tb_mxint_linear_ctrl.sv
// Bench for mxint_linear_ctrl: a bias-enabled and a bias-less instance share
// start/reset/output-beat stimulus and are scored against an in-order stream model.
module tb_mxint_linear_ctrl;

    localparam int WD = 259;
    localparam int BD = 67;
    localparam int NW = 25;
    localparam int NB = 5;
    localparam int NBEAT = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, out_valid, out_ready, weight_ready, bias_ready;
    logic busy, done, wmem_en, bmem_en, weight_valid, bias_valid;
    logic [4:0] wmem_addr;
    logic [2:0] bmem_addr;
    logic [WD-1:0] wmem_rdata;
    logic [BD-1:0] bmem_rdata;
    logic [15:0] mweight [16];
    logic [2:0] eweight;
    logic [15:0] mbias [4];
    logic [2:0] ebias;

    logic busy_n, done_n, wmem_en_n, bmem_en_n, weight_valid_n, bias_valid_n;
    logic [4:0] wmem_addr_n;
    logic [2:0] bmem_addr_n;
    logic [WD-1:0] wmem_rdata_n;
    logic [BD-1:0] bmem_rdata_n = '0;
    logic [15:0] mweight_n [16];
    logic [2:0] eweight_n;
    logic [15:0] mbias_n [4];
    logic [2:0] ebias_n;
    logic wr_n = 1'b1;
    logic br_n = 1'b1;

    mxint_linear_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .wmem_en(wmem_en), .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata),
        .bmem_en(bmem_en), .bmem_addr(bmem_addr), .bmem_rdata(bmem_rdata),
        .mweight(mweight), .eweight(eweight), .weight_valid(weight_valid), .weight_ready(weight_ready),
        .mbias(mbias), .ebias(ebias), .bias_valid(bias_valid), .bias_ready(bias_ready),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mxint_linear_ctrl #(.HAS_BIAS(0)) dut_nb (
        .clk(clk), .rst(rst), .start(start), .busy(busy_n), .done(done_n),
        .wmem_en(wmem_en_n), .wmem_addr(wmem_addr_n), .wmem_rdata(wmem_rdata_n),
        .bmem_en(bmem_en_n), .bmem_addr(bmem_addr_n), .bmem_rdata(bmem_rdata_n),
        .mweight(mweight_n), .eweight(eweight_n), .weight_valid(weight_valid_n), .weight_ready(wr_n),
        .mbias(mbias_n), .ebias(ebias_n), .bias_valid(bias_valid_n), .bias_ready(br_n),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    // Memory contents and 1-cycle-latency read ports
    logic [WD-1:0] wmem [NW];
    logic [BD-1:0] bmem [NB];
    always @(posedge clk) begin
        if (wmem_en)   wmem_rdata   <= wmem[wmem_addr];
        if (wmem_en_n) wmem_rdata_n <= wmem[wmem_addr_n];
        if (bmem_en)   bmem_rdata   <= bmem[bmem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit rnd_mode = 1'b0;
    initial begin
        weight_ready = 1'b1;
        bias_ready   = 1'b1;
        forever begin
            @(posedge clk); #1;
            weight_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bias_ready   = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic logic [WD-1:0] pack_w();
        logic [WD-1:0] r;
        for (int p = 0; p < 16; p++) r[p*16 +: 16] = mweight[p];
        r[WD-1 -: 3] = eweight;
        return r;
    endfunction
    function automatic logic [WD-1:0] pack_wn();
        logic [WD-1:0] r;
        for (int p = 0; p < 16; p++) r[p*16 +: 16] = mweight_n[p];
        r[WD-1 -: 3] = eweight_n;
        return r;
    endfunction
    function automatic logic [BD-1:0] pack_b();
        logic [BD-1:0] r;
        for (int p = 0; p < 4; p++) r[p*16 +: 16] = mbias[p];
        r[BD-1 -: 3] = ebias;
        return r;
    endfunction
    function automatic logic [BD-1:0] pack_bn();
        logic [BD-1:0] r;
        for (int p = 0; p < 4; p++) r[p*16 +: 16] = mbias_n[p];
        r[BD-1 -: 3] = ebias_n;
        return r;
    endfunction

    // Reference model: the k-th handshake on a stream must carry block k,
    // and the k-th read must use address k.
    bit mon_clr = 1'b0;
    int w_rd, w_hs, w_aerr, w_derr, w_serr, b_rd, b_hs, b_aerr, b_derr, b_serr;
    int n_hs, n_derr, n_berr, beats, beat25_cyc, done_cnt, done_cyc, n_done_cnt, n_done_cyc;
    int first_en, first_wv, last_en;
    bit w_stall, b_stall;
    logic [WD-1:0] w_prev;
    logic [BD-1:0] b_prev;

    always @(negedge clk) begin
        if (mon_clr) begin
            w_rd <= 0; w_hs <= 0; w_aerr <= 0; w_derr <= 0; w_serr <= 0;
            b_rd <= 0; b_hs <= 0; b_aerr <= 0; b_derr <= 0; b_serr <= 0;
            n_hs <= 0; n_derr <= 0; n_berr <= 0; beats <= 0; beat25_cyc <= -1;
            done_cnt <= 0; done_cyc <= -1; n_done_cnt <= 0; n_done_cyc <= -1;
            first_en <= -1; first_wv <= -1; last_en <= -1;
            w_stall <= 1'b0; b_stall <= 1'b0;
        end else begin
            if (wmem_en) begin
                if (int'(wmem_addr) != w_rd) w_aerr <= w_aerr + 1;
                if (w_rd == 0) first_en <= cyc;
                last_en <= cyc;
                w_rd <= w_rd + 1;
            end
            if (bmem_en) begin
                if (int'(bmem_addr) != b_rd) b_aerr <= b_aerr + 1;
                b_rd <= b_rd + 1;
            end
            if (weight_valid && first_wv < 0) first_wv <= cyc;
            if (weight_valid && weight_ready) begin
                if (w_hs >= NW) w_derr <= w_derr + 1;
                else if (pack_w() !== wmem[w_hs]) w_derr <= w_derr + 1;
                w_hs <= w_hs + 1;
            end
            if (bias_valid && bias_ready) begin
                if (b_hs >= NB) b_derr <= b_derr + 1;
                else if (pack_b() !== bmem[b_hs]) b_derr <= b_derr + 1;
                b_hs <= b_hs + 1;
            end
            if (w_stall && (!weight_valid || pack_w() !== w_prev)) w_serr <= w_serr + 1;
            if (b_stall && (!bias_valid || pack_b() !== b_prev)) b_serr <= b_serr + 1;
            w_stall <= weight_valid && !weight_ready;
            b_stall <= bias_valid && !bias_ready;
            w_prev  <= pack_w();
            b_prev  <= pack_b();
            if (weight_valid_n) begin
                if (n_hs >= NW) n_derr <= n_derr + 1;
                else if (pack_wn() !== wmem[n_hs]) n_derr <= n_derr + 1;
                n_hs <= n_hs + 1;
            end
            if (bias_valid_n || bmem_en_n || bmem_addr_n != 3'd0 || pack_bn() != '0)
                n_berr <= n_berr + 1;
            if (out_valid && out_ready) begin
                beats <= beats + 1;
                if (beats == NBEAT - 1) beat25_cyc <= cyc;
            end
            if (done)   begin done_cnt <= done_cnt + 1;     done_cyc <= cyc;   end
            if (done_n) begin n_done_cnt <= n_done_cnt + 1; n_done_cyc <= cyc; end
        end
    end

    int n_pass = 0;
    int n_tot  = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit rnd;      // randomised ready on both streams
        int early;    // output beats injected during LOAD
        int gap;      // stalled (valid, !ready) cycles after each later beat
        bit extra;    // one more beat after the 25th
        int repulse;  // LOAD cycle at which start is pulsed again (0 = none)
        int exp_w;
        int exp_b;
        bit contig;   // expect reads back-to-back and first-data latency
    } vec_t;

    task automatic fill_mem();
        logic [287:0] tw;
        logic [95:0]  tb;
        for (int i = 0; i < NW; i++) begin
            for (int k = 0; k < 9; k++) tw[k*32 +: 32] = $urandom;
            wmem[i] = tw[WD-1:0];
        end
        for (int i = 0; i < NB; i++) begin
            for (int k = 0; k < 3; k++) tb[k*32 +: 32] = $urandom;
            bmem[i] = tb[BD-1:0];
        end
    endtask

    task automatic run_case(input vec_t v, input int id);
        int start_cyc, t;
        string tag;
        tag = $sformatf("v%0d", id);
        rnd_mode = v.rnd;
        fill_mem();
        mon_clr = 1'b1; tick(); mon_clr = 1'b0;
        start = 1'b1; start_cyc = cyc; tick(); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            out_valid = (i < v.early);
            out_ready = (i < v.early);
            start     = (v.repulse != 0) && (i == v.repulse);
            tick();
        end
        out_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        t = 0;
        while (!(w_hs == v.exp_w && b_hs == v.exp_b && n_hs == v.exp_w) && t < 600) begin
            tick(); t++;
        end
        chk({tag, "_stream_timeout"}, longint'(t < 600), 1);
        for (int b = 0; b < NBEAT - v.early; b++) begin
            out_valid = 1'b1; out_ready = 1'b1; tick();
            for (int g = 0; g < v.gap; g++) begin out_ready = 1'b0; tick(); end
        end
        if (v.extra) begin out_valid = 1'b1; out_ready = 1'b1; tick(); end
        out_valid = 1'b0; out_ready = 1'b0;
        repeat (4) tick();
        chk({tag, "_w_hs"},      w_hs, v.exp_w);
        chk({tag, "_b_hs"},      b_hs, v.exp_b);
        chk({tag, "_w_reads"},   w_rd, v.exp_w);
        chk({tag, "_b_reads"},   b_rd, v.exp_b);
        chk({tag, "_addr_err"},  w_aerr + b_aerr, 0);
        chk({tag, "_data_err"},  w_derr + b_derr, 0);
        chk({tag, "_stab_err"},  w_serr + b_serr, 0);
        chk({tag, "_done_cnt"},  done_cnt, 1);
        chk({tag, "_done_cyc"},  done_cyc, beat25_cyc + 1);
        chk({tag, "_busy_end"},  busy, 0);
        chk({tag, "_nb_w_hs"},   n_hs, v.exp_w);
        chk({tag, "_nb_data"},   n_derr, 0);
        chk({tag, "_nb_bias"},   n_berr, 0);
        chk({tag, "_nb_done"},   n_done_cnt, 1);
        chk({tag, "_nb_donecyc"}, n_done_cyc, beat25_cyc + 1);
        if (v.contig) begin
            chk({tag, "_en_lat"},  first_en - start_cyc, 1);
            chk({tag, "_wv_lat"},  first_wv - first_en, 2);
            chk({tag, "_no_bubble"}, last_en - first_en, NW - 1);
        end
    endtask

    vec_t vecs [4];

    initial begin
        rst = 1'b1; start = 1'b0; out_valid = 1'b0; out_ready = 1'b0;
        vecs[0] = '{rnd:1'b0, early:0,  gap:0, extra:1'b1, repulse:0, exp_w:NW, exp_b:NB, contig:1'b1};
        vecs[1] = '{rnd:1'b1, early:0,  gap:1, extra:1'b1, repulse:0, exp_w:NW, exp_b:NB, contig:1'b0};
        vecs[2] = '{rnd:1'b1, early:5,  gap:2, extra:1'b0, repulse:6, exp_w:NW, exp_b:NB, contig:1'b0};
        vecs[3] = '{rnd:1'b0, early:10, gap:0, extra:1'b1, repulse:3, exp_w:NW, exp_b:NB, contig:1'b1};

        repeat (3) tick();
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_wmem_en", wmem_en, 0);
        chk("rst_bmem_en", bmem_en, 0);
        chk("rst_wvalid", weight_valid, 0);
        chk("rst_bvalid", bias_valid, 0);
        chk("rst_nb_busy", busy_n, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) run_case(vecs[i], i);

        // Reset in the middle of LOAD after some beats, then a fresh run.
        rnd_mode = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        out_valid = 1'b1; out_ready = 1'b1;
        repeat (10) tick();
        out_valid = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        chk("midrun_busy", busy, 1);
        rst = 1'b1; tick();
        chk("midrst_busy",   busy, 0);
        chk("midrst_wmem_en", wmem_en, 0);
        chk("midrst_wvalid", weight_valid, 0);
        rst = 1'b0;
        tick();
        run_case(vecs[0], 4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
